instr_issue: RTL

//  Fetch/issue front end of the single-cycle-decode CPU. Owns the PC, reads instruction words

---
 rtl/cpu_pkg.sv | 18 +
 rtl/instr_issue_pc_reg.sv | 27 ++
 rtl/instr_issue.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and the fetch/issue state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 2'b00;
  localparam logic [OPC_W-1:0] OP_LW    = 2'b01;
  localparam logic [OPC_W-1:0] OP_SW    = 2'b10;
  localparam logic [OPC_W-1:0] OP_BEQ   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    WAIT  = 2'b10,
    ISSUE = 2'b11
  } state_t;

endpackage

// File: rtl/instr_issue_pc_reg.sv
// Program counter: branch load has priority over increment; increment wraps naturally.
module pc_reg #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_inc,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_issue.sv
// Fetch/issue front end: fetches one word per instruction from a 1-cycle-latency
// memory and presents it to decode behind a valid/ready handshake.
module instr_issue
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OPC_LSB = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [INSTR_W-1:0] instr,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic               busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_imem_en;
  logic               r_issue_valid;
  logic               r_busy;
  logic               r_stop_pend;
  logic [INSTR_W-1:0] r_instr;
  logic [OPC_W-1:0]   r_opcode;
  logic [PC_W-1:0]    w_pc;
  logic               w_hs;
  logic               w_branch;
  logic               w_inc;

  assign w_hs     = r_issue_valid & issue_ready;
  assign w_branch = w_hs & (r_opcode == OP_BEQ) & branch_taken;
  assign w_inc    = w_hs & ~w_branch;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_branch),
    .i_inc    (w_inc),
    .i_target (branch_target),
    .o_pc     (w_pc)
  );

  // A stop seen in the handshake cycle itself counts as pending.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = WAIT;
      WAIT:    w_state_nxt = ISSUE;
      ISSUE:   if (w_hs) w_state_nxt = (r_stop_pend | stop) ? IDLE : FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control outputs are registered from the next state so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_en     <= 1'b0;
      r_issue_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_instr       <= '0;
      r_opcode      <= '0;
    end else begin
      r_imem_en     <= (w_state_nxt == FETCH);
      r_issue_valid <= (w_state_nxt == ISSUE);
      r_busy        <= (w_state_nxt != IDLE);
      if (w_state_nxt == IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (stop && (r_state != IDLE)) begin
        r_stop_pend <= 1'b1;
      end
      if (r_state == WAIT) begin
        r_instr  <= imem_data;
        r_opcode <= imem_data[OPC_LSB+1:OPC_LSB];
      end
    end
  end

  assign imem_en     = r_imem_en;
  assign imem_addr   = w_pc;
  assign issue_valid = r_issue_valid;
  assign opcode      = r_opcode;
  assign instr       = r_instr;
  assign pc          = w_pc;
  assign busy        = r_busy;

endmodule
